// File: rtl/xgmii_tx_fifo_reader.sv
// Read side of the TX clock-crossing FIFO: drains XGMII words to the 64b/66b encoder,
// fills /I/ between frames, replaces a mid-frame underrun with /E/ and discards the rest of that frame.
module xgmii_tx_fifo_reader #(
  parameter int unsigned DSIZE = 72,
  parameter int unsigned CNT_W = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  input  logic             tx_ready,
  output logic [63:0]      tx_data,
  output logic [7:0]       tx_ctrl,
  output logic             in_frame,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [7:0]  CTRL_ALL = 8'hFF;
  localparam logic [63:0] IDLE_D   = 64'h0707070707070707;
  localparam logic [63:0] ERR_D    = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [7:0]  START_B  = 8'hFB;
  localparam logic [7:0]  TERM_B   = 8'hFD;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FRAME   = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e           state_q;
  logic [63:0]      tx_data_q;
  logic [7:0]       tx_ctrl_q;
  logic             in_frame_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] underrun_cnt_q;
  logic [CNT_W-1:0] drop_cnt_q;

  logic [7:0]  head_ctrl;
  logic [63:0] head_data;
  logic        is_start;
  logic        is_term;

  assign head_ctrl = rdata[DSIZE-1 -: 8];
  assign head_data = rdata[63:0];
  assign is_start  = head_ctrl[0] & (head_data[7:0] == START_B);

  // Terminate may sit in any lane.
  always_comb begin
    is_term = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (head_ctrl[i] && (head_data[8*i +: 8] == TERM_B)) is_term = 1'b1;
    end
  end

  // Pop is independent of state so the FIFO drains at line rate whenever the encoder accepts.
  assign rinc = tx_ready & ~rempty & ~rrst;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q        <= ST_IDLE;
      tx_data_q      <= IDLE_D;
      tx_ctrl_q      <= CTRL_ALL;
      in_frame_q     <= 1'b0;
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
      drop_cnt_q     <= '0;
    end else if (tx_ready) begin
      case (state_q)
        ST_FRAME: begin
          if (rempty) begin
            tx_data_q      <= ERR_D;
            tx_ctrl_q      <= CTRL_ALL;
            underrun_cnt_q <= sat_inc(underrun_cnt_q);
            state_q        <= ST_DISCARD;
            in_frame_q     <= 1'b0;
          end else begin
            tx_data_q <= head_data;
            tx_ctrl_q <= head_ctrl;
            if (is_term) begin
              frame_cnt_q <= sat_inc(frame_cnt_q);
              state_q     <= ST_IDLE;
              in_frame_q  <= 1'b0;
            end
          end
        end
        // IDLE and DISCARD share start handling; they differ only in how a terminate is treated.
        default: begin
          if (rempty) begin
            tx_data_q <= IDLE_D;
            tx_ctrl_q <= CTRL_ALL;
          end else if (is_start) begin
            tx_data_q <= head_data;
            tx_ctrl_q <= head_ctrl;
            if (is_term) begin
              frame_cnt_q <= sat_inc(frame_cnt_q);
              state_q     <= ST_IDLE;
              in_frame_q  <= 1'b0;
            end else begin
              state_q    <= ST_FRAME;
              in_frame_q <= 1'b1;
            end
          end else begin
            tx_data_q  <= IDLE_D;
            tx_ctrl_q  <= CTRL_ALL;
            drop_cnt_q <= sat_inc(drop_cnt_q);
            if (state_q == ST_DISCARD && is_term) state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_ctrl      = tx_ctrl_q;
  assign in_frame     = in_frame_q;
  assign frame_cnt    = frame_cnt_q;
  assign underrun_cnt = underrun_cnt_q;
  assign drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_xgmii_tx_fifo_reader.sv
// Bench for xgmii_tx_fifo_reader: queue-modelled FIFO, expected output words queued per cycle.
module tb_xgmii_tx_fifo_reader;

  localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] ERR_W  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};
  localparam logic [71:0] START  = {8'h01, 64'hD5555555555555FB};
  localparam logic [71:0] TERM   = {8'hFF, 64'h07070707070707FD};
  localparam logic [71:0] STT    = {8'h81, 64'hFD000000000000FB};
  localparam logic [71:0] D1     = {8'h00, 64'h1111111111111111};
  localparam logic [71:0] D2     = {8'h00, 64'h2222222222222222};
  localparam logic [71:0] D3     = {8'h00, 64'h3333333333333333};
  localparam logic [71:0] D4     = {8'h00, 64'h4444444444444444};
  localparam logic [71:0] D5     = {8'h00, 64'h5555555555555555};

  logic        rclk, rrst, rempty, rinc, tx_ready, in_frame;
  logic [71:0] rdata;
  logic [63:0] tx_data;
  logic [7:0]  tx_ctrl;
  logic [15:0] frame_cnt, underrun_cnt, drop_cnt;

  logic [71:0] fifo[$];
  logic [71:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        push;
    logic [71:0] w;
    logic        rdy;
    logic [71:0] exp;
    logic [15:0] f;
    logic [15:0] d;
    logic        inf;
  } vec_t;

  vec_t tbl[14];

  xgmii_tx_fifo_reader #(.DSIZE(72), .CNT_W(16)) dut (
    .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_ctrl(tx_ctrl), .in_frame(in_frame),
    .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt), .drop_cnt(drop_cnt)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: present FIFO head, check pop strobe, then check the registered output word.
  task automatic cyc(input logic rdy);
    logic popped;
    logic [71:0] e;
    tx_ready = rdy;
    rempty   = (fifo.size() == 0);
    rdata    = rempty ? 72'h0 : fifo[0];
    #1;
    chk("rinc", 72'(rinc), 72'(rdy & ~rempty & ~rrst));
    popped = rinc;
    @(posedge rclk);
    if (popped) void'(fifo.pop_front());
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got no expected word for tx %h", {tx_ctrl, tx_data});
    end else begin
      e = exp_q.pop_front();
      chk("tx", {tx_ctrl, tx_data}, e);
    end
  endtask

  task automatic cnt(input logic [15:0] f, input logic [15:0] u, input logic [15:0] d, input logic inf);
    chk("frame_cnt", 72'(frame_cnt), 72'(f));
    chk("underrun_cnt", 72'(underrun_cnt), 72'(u));
    chk("drop_cnt", 72'(drop_cnt), 72'(d));
    chk("in_frame", 72'(in_frame), 72'(inf));
  endtask

  initial begin
    tbl[0]  = '{1'b1, START, 1'b1, START,  16'd0, 16'd0, 1'b1};
    tbl[1]  = '{1'b1, D1,    1'b1, D1,     16'd0, 16'd0, 1'b1};
    tbl[2]  = '{1'b1, D2,    1'b1, D2,     16'd0, 16'd0, 1'b1};
    tbl[3]  = '{1'b1, D3,    1'b1, D3,     16'd0, 16'd0, 1'b1};
    tbl[4]  = '{1'b1, TERM,  1'b1, TERM,   16'd1, 16'd0, 1'b0};
    tbl[5]  = '{1'b0, D1,    1'b1, IDLE_W, 16'd1, 16'd0, 1'b0};
    tbl[6]  = '{1'b1, D4,    1'b1, IDLE_W, 16'd1, 16'd1, 1'b0};
    tbl[7]  = '{1'b1, D5,    1'b1, IDLE_W, 16'd1, 16'd2, 1'b0};
    tbl[8]  = '{1'b1, STT,   1'b1, STT,    16'd2, 16'd2, 1'b0};
    tbl[9]  = '{1'b1, START, 1'b1, START,  16'd2, 16'd2, 1'b1};
    tbl[10] = '{1'b1, TERM,  1'b1, TERM,   16'd3, 16'd2, 1'b0};
    tbl[11] = '{1'b1, START, 1'b1, START,  16'd3, 16'd2, 1'b1};
    tbl[12] = '{1'b1, TERM,  1'b1, TERM,   16'd4, 16'd2, 1'b0};
    tbl[13] = '{1'b0, D1,    1'b0, TERM,   16'd4, 16'd2, 1'b0};

    rrst = 1'b1; tx_ready = 1'b1; rempty = 1'b1; rdata = '0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(IDLE_W);
      cyc(1'b1);
    end
    cnt(16'd0, 16'd0, 16'd0, 1'b0);
    rrst = 1'b0;

    // Single-word vectors: frame, idle drops, start+term word, back-to-back frames, stall hold.
    foreach (tbl[i]) begin
      if (tbl[i].push) fifo.push_back(tbl[i].w);
      exp_q.push_back(tbl[i].exp);
      cyc(tbl[i].rdy);
      cnt(tbl[i].f, 16'd0, tbl[i].d, tbl[i].inf);
    end

    // Underrun mid-frame, then late words discarded through the terminate.
    fifo.push_back(START); fifo.push_back(D1);
    exp_q.push_back(START); cyc(1'b1);
    exp_q.push_back(D1);    cyc(1'b1);
    exp_q.push_back(ERR_W); cyc(1'b1);
    cnt(16'd4, 16'd1, 16'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin exp_q.push_back(IDLE_W); cyc(1'b1); end
    fifo.push_back(D2); fifo.push_back(D3); fifo.push_back(TERM);
    for (int i = 0; i < 4; i++) begin exp_q.push_back(IDLE_W); cyc(1'b1); end
    cnt(16'd4, 16'd1, 16'd5, 1'b0);

    // Encoder stall mid-frame with data waiting.
    fifo.push_back(START); fifo.push_back(D1); fifo.push_back(D2);
    fifo.push_back(D3); fifo.push_back(TERM);
    exp_q.push_back(START); cyc(1'b1);
    exp_q.push_back(D1);    cyc(1'b1);
    for (int i = 0; i < 3; i++) begin exp_q.push_back(D1); cyc(1'b0); end
    chk("fifo_held", 72'(fifo.size()), 72'd3);
    exp_q.push_back(D2);     cyc(1'b1);
    exp_q.push_back(D3);     cyc(1'b1);
    exp_q.push_back(TERM);   cyc(1'b1);
    exp_q.push_back(IDLE_W); cyc(1'b1);
    cnt(16'd5, 16'd1, 16'd5, 1'b0);

    // Start arriving while discarding opens a new frame without a drop.
    fifo.push_back(START);
    exp_q.push_back(START); cyc(1'b1);
    exp_q.push_back(ERR_W); cyc(1'b1);
    fifo.push_back(START); fifo.push_back(TERM);
    exp_q.push_back(START); cyc(1'b1);
    chk("in_frame_disc_start", 72'(in_frame), 72'd1);
    exp_q.push_back(TERM);  cyc(1'b1);
    cnt(16'd6, 16'd2, 16'd5, 1'b0);

    // Reset mid-frame: no /E/, FIFO left intact, leftover word dropped from IDLE.
    fifo.push_back(START); fifo.push_back(D1);
    exp_q.push_back(START); cyc(1'b1);
    rrst = 1'b1;
    exp_q.push_back(IDLE_W); cyc(1'b1);
    cnt(16'd0, 16'd0, 16'd0, 1'b0);
    rrst = 1'b0;
    exp_q.push_back(IDLE_W); cyc(1'b1);
    cnt(16'd0, 16'd0, 16'd1, 1'b0);
    chk("fifo_left", 72'(fifo.size()), 72'd0);

    // Underrun counter saturation.
    force dut.underrun_cnt_q = 16'hFFFF;
    #1;
    release dut.underrun_cnt_q;
    fifo.push_back(START);
    exp_q.push_back(START);  cyc(1'b1);
    exp_q.push_back(ERR_W);  cyc(1'b1);
    cnt(16'd0, 16'hFFFF, 16'd1, 1'b0);
    exp_q.push_back(IDLE_W); cyc(1'b1);
    cnt(16'd0, 16'hFFFF, 16'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
